// File: rtl/intc_pkg.sv
// Shared constants and the priority-encode helper for the external interrupt controller.
package intc_pkg;

  localparam int unsigned INTC_NUM_SRC = 3;

  localparam logic [1:0] INTC_LVL_NONE = 2'd0;
  localparam logic [1:0] INTC_LVL_1    = 2'd1;
  localparam logic [1:0] INTC_LVL_2    = 2'd2;
  localparam logic [1:0] INTC_LVL_3    = 2'd3;

  // Highest set bit index + 1, or 0 for an empty mask.
  function automatic logic [1:0] intc_top_level(input logic [INTC_NUM_SRC-1:0] mask);
    if (mask[2])      return INTC_LVL_3;
    else if (mask[1]) return INTC_LVL_2;
    else if (mask[0]) return INTC_LVL_1;
    else              return INTC_LVL_NONE;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// Per-source request synchroniser: SYNC_STAGES-flop chain plus a history flop for edge detect.
module intc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~hist_q;

endmodule

// File: rtl/int_controller.sv
// External interrupt controller for CP0: pending/enable/in-service tracking with nesting.
// Define INTC_LEVEL_EN for level-sensitive sources; default is edge-triggered latching.
module int_controller
  import intc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INTC_NUM_SRC-1:0] irq_in,
  input  logic                    en_we,
  input  logic [INTC_NUM_SRC-1:0] en_wdata,
  input  logic                    ovf_clr,
  input  logic                    take,
  input  logic                    eret,
  output logic [2:0]              interruptSignal,
  output logic [INTC_NUM_SRC-1:0] pending,
  output logic [INTC_NUM_SRC-1:0] in_service,
  output logic [INTC_NUM_SRC-1:0] overrun
);

  logic [INTC_NUM_SRC-1:0] lvl_w, rise_w;
  logic [INTC_NUM_SRC-1:0] en_q, en_d;
  logic [INTC_NUM_SRC-1:0] pending_q, pending_d;
  logic [INTC_NUM_SRC-1:0] in_service_q, in_service_d;
  logic [INTC_NUM_SRC-1:0] overrun_q, overrun_d;
  logic [1:0]              int_q, int_d;
  logic [1:0]              cur, cand;
  logic [INTC_NUM_SRC-1:0] take_mask, pop_mask;

  for (genvar i = 0; i < INTC_NUM_SRC; i++) begin : g_src
    intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in[i]),
      .lvl    (lvl_w[i]),
      .rise   (rise_w[i])
    );
  end

  always_comb begin
    cur  = intc_top_level(in_service_q);
    cand = intc_top_level(pending_q & en_q);
    int_d = (cand > cur) ? cand : INTC_LVL_NONE;

    take_mask = '0;
    if (take && (int_q != INTC_LVL_NONE)) take_mask = 3'b001 << (int_q - 2'd1);
    pop_mask = '0;
    if (eret && (cur != INTC_LVL_NONE)) pop_mask = 3'b001 << (cur - 2'd1);

    // Pop before push so a same-cycle take/eret nets to the newly accepted level.
    in_service_d = (in_service_q & ~pop_mask) | take_mask;
    en_d         = en_we ? en_wdata : en_q;
`ifdef INTC_LEVEL_EN
    pending_d = lvl_w;
    overrun_d = '0;
`else
    // A fresh edge on the source being taken keeps it pending and is not an overrun.
    pending_d = (pending_q & ~take_mask) | rise_w;
    overrun_d = (ovf_clr ? '0 : overrun_q) | (rise_w & pending_q & ~take_mask);
`endif
  end

`ifndef INTC_LEVEL_EN
  always_comb begin
    assert ((rise_w & ~lvl_w) == '0);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      overrun_q    <= '0;
      int_q        <= INTC_LVL_NONE;
    end else begin
      en_q         <= en_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      overrun_q    <= overrun_d;
      int_q        <= int_d;
    end
  end

  assign interruptSignal = {1'b0, int_q};
  assign pending         = pending_q;
  assign in_service      = in_service_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller (edge-triggered build, SYNC_STAGES = 2).
module tb_int_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq_in;
  logic       en_we;
  logic [2:0] en_wdata;
  logic       ovf_clr;
  logic       take;
  logic       eret;
  logic [2:0] interruptSignal;
  logic [2:0] pending;
  logic [2:0] in_service;
  logic [2:0] overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int_controller #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_in          (irq_in),
    .en_we           (en_we),
    .en_wdata        (en_wdata),
    .ovf_clr         (ovf_clr),
    .take            (take),
    .eret            (eret),
    .interruptSignal (interruptSignal),
    .pending         (pending),
    .in_service      (in_service),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle request; returns once the pending bit has been latched.
  task automatic pulse(input logic [2:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
    tick();
    tick();
  endtask

  task automatic write_en(input logic [2:0] m);
    en_we = 1'b1; en_wdata = m;
    tick();
    en_we = 1'b0;
  endtask

  task automatic do_take();
    take = 1'b1; tick(); take = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; en_we = 1'b0; en_wdata = '0;
    ovf_clr = 1'b0; take = 1'b0; eret = 1'b0;
    tick(); tick();
    check("rst_int", interruptSignal, 3'd0);
    check("rst_pend", pending, 3'b000);
    check("rst_isvc", in_service, 3'b000);
    check("rst_ovf", overrun, 3'b000);
    rst = 1'b0;
    tick();

    // Basic present/take
    write_en(3'b111);
    pulse(3'b010);
    check("l2_pend", pending, 3'b010);
    check("l2_int_early", interruptSignal, 3'd0);
    tick();
    check("l2_int", interruptSignal, 3'd2);
    do_take();
    check("l2_take_isvc", in_service, 3'b010);
    check("l2_take_pend", pending, 3'b000);
    tick();
    check("l2_take_int", interruptSignal, 3'd0);

    // Nesting
    pulse(3'b001);
    tick();
    check("l1_blocked", interruptSignal, 3'd0);
    pulse(3'b100);
    tick();
    check("l3_int", interruptSignal, 3'd3);
    do_take();
    check("l3_isvc", in_service, 3'b110);
    check("l3_pend", pending, 3'b001);
    do_eret();
    check("eret1_isvc", in_service, 3'b010);
    tick();
    check("eret1_int", interruptSignal, 3'd0);
    do_eret();
    check("eret2_isvc", in_service, 3'b000);
    tick();
    check("eret2_int", interruptSignal, 3'd1);
    do_take();
    tick();
    do_eret();
    tick();

    // Enable masking and ignored take
    write_en(3'b000);
    pulse(3'b100);
    check("dis_pend", pending, 3'b100);
    tick();
    check("dis_int", interruptSignal, 3'd0);
    do_take();
    check("take0_isvc", in_service, 3'b000);
    check("take0_pend", pending, 3'b100);
    write_en(3'b100);
    check("en_int_same", interruptSignal, 3'd0);
    tick();
    check("en_int_next", interruptSignal, 3'd3);
    do_take();
    tick();
    do_eret();
    write_en(3'b111);

    // Overrun
    pulse(3'b001);
    check("ovf_none", overrun, 3'b000);
    pulse(3'b001);
    check("ovf_set", overrun, 3'b001);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", overrun, 3'b000);
    irq_in = 3'b001; tick(); irq_in = '0; tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_setwins", overrun, 3'b001);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Take coincident with a new edge on the presented source
    check("coin_pre_int", interruptSignal, 3'd1);
    irq_in = 3'b001; tick(); irq_in = '0; tick();
    do_take();
    check("coin_pend", pending, 3'b001);
    check("coin_isvc", in_service, 3'b001);
    check("coin_ovf", overrun, 3'b000);
    tick();
    check("coin_int", interruptSignal, 3'd0);
    do_eret();
    tick();
    check("coin_repres", interruptSignal, 3'd1);

    // Asynchronous reset mid-operation
    do_take();
    pulse(3'b010);
    tick();
    check("pre_rst_l2", interruptSignal, 3'd2);
    do_take();
    pulse(3'b100);
    tick();
    check("pre_rst_int", interruptSignal, 3'd3);
    check("pre_rst_isvc", in_service, 3'b011);
    #2 rst = 1'b1;
    #1;
    check("arst_int", interruptSignal, 3'd0);
    check("arst_pend", pending, 3'b000);
    check("arst_isvc", in_service, 3'b000);
    check("arst_ovf", overrun, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Simultaneous take and eret
    write_en(3'b111);
    pulse(3'b001);
    tick();
    check("te_l1", interruptSignal, 3'd1);
    do_take();
    pulse(3'b010);
    tick();
    check("te_l2", interruptSignal, 3'd2);
    take = 1'b1; eret = 1'b1; tick(); take = 1'b0; eret = 1'b0;
    check("te_isvc", in_service, 3'b010);
    check("te_pend", pending, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
